// File: rtl/tpu_pkg.sv
// TPU sequencer shared types.
// Opcodes, FSM states and instruction field widths.
package tpu_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 3;
  localparam int OPND_W  = 13;

  typedef enum logic [OPC_W-1:0] {
    NOP_END     = 3'd0,
    LOAD_ADDR   = 3'd1,
    LOAD_WEIGHT = 3'd2,
    LOAD_INPUT  = 3'd3,
    COMPUTE     = 3'd4,
    STORE       = 3'd5
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXECUTE,
    COMPUTE_WAIT,
    DONE,
    ERROR
  } state_e;

  function automatic logic [OPC_W-1:0] opc_of(
    input logic [INSTR_W-1:0] w
  );
    return w[OPND_W +: OPC_W];
  endfunction

  function automatic logic is_xfer(
    input logic [OPC_W-1:0] op
  );
    return (op == LOAD_ADDR)   ||
           (op == LOAD_WEIGHT) ||
           (op == LOAD_INPUT)  ||
           (op == STORE);
  endfunction

endpackage

// File: rtl/tpu_sequencer_if.sv
// Instruction memory bus.
// One host write port and one async read port.
interface tpu_sequencer_if
  import tpu_pkg::*;
#(
  parameter int AW = 3
) ();

  logic               we;
  logic [AW-1:0]      waddr;
  logic [INSTR_W-1:0] wdata;
  logic [AW-1:0]      raddr;
  logic [INSTR_W-1:0] rdata;

  modport master (
    output we, waddr, wdata, raddr,
    input  rdata
  );

  modport slave (
    input  we, waddr, wdata, raddr,
    output rdata
  );

endinterface

// File: rtl/instr_mem.sv
// Instruction storage for the sequencer.
// Contents are deliberately left out of reset.
module instr_mem
  import tpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic             clk,
  tpu_sequencer_if.slave  bus
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  // host write port; survives reset
  always_ff @(posedge clk) begin
    if (bus.we) begin
      mem_q[bus.waddr] <= bus.wdata;
    end
  end

  assign bus.rdata = mem_q[bus.raddr];

endmodule

// File: rtl/tpu_sequencer.sv
// TPU program sequencer.
// Fetches words and presents them to control_unit.
module tpu_sequencer
  import tpu_pkg::*;
#(
  parameter  int IMEM_DEPTH     = 8,
  parameter  int COMPUTE_CYCLES = 6,
  localparam int AW = $clog2(IMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  output logic [INSTR_W-1:0] instruction,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [AW-1:0]      pc
);

  localparam logic [AW-1:0] PC_LAST = AW'(IMEM_DEPTH - 1);
  localparam logic [7:0]    CNT_LAST = 8'(COMPUTE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               retire;
  logic [OPC_W-1:0]   op;

  tpu_sequencer_if #(.AW(AW)) mem_bus ();

  assign mem_bus.we    = prog_we & (state_q == IDLE);
  assign mem_bus.waddr = prog_addr;
  assign mem_bus.wdata = prog_data;
  assign mem_bus.raddr = pc_q;

  instr_mem #(
    .DEPTH(IMEM_DEPTH)
  ) u_imem (
    .clk(clk),
    .bus(mem_bus)
  );

  assign op = opc_of(ir_q);

  // next state, pc, IR, compute counter, sticky error
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    retire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
          err_d   = 1'b0;
        end
      end
      FETCH: begin
        ir_d    = mem_bus.rdata;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        unique case (1'b1)
          op == NOP_END: state_d = DONE;
          is_xfer(op):   retire  = 1'b1;
          op == COMPUTE: begin
            if (CNT_LAST == 8'd0) begin
              retire = 1'b1;
            end else begin
              cnt_d   = 8'd1;
              state_d = COMPUTE_WAIT;
            end
          end
          default: begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        endcase
      end
      COMPUTE_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          retire = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (retire) begin
      cnt_d = '0;
      if (pc_q == PC_LAST) begin
        state_d = DONE;
      end else begin
        pc_d    = pc_q + AW'(1);
        state_d = FETCH;
      end
    end
  end

  // word shown to control_unit in the cycle state_d takes effect
  always_comb begin
    instr_d = '0;
    if (state_d == EXECUTE &&
        (is_xfer(opc_of(ir_d)) ||
         opc_of(ir_d) == COMPUTE)) begin
      instr_d = ir_d;
    end
    if (state_d == COMPUTE_WAIT) begin
      instr_d = ir_q;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign instruction = instr_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign error       = err_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Bench for tpu_sequencer.
// Per-cycle trace model plus literal pins.
module tb_tpu_sequencer;

  localparam int D = 8;
  localparam int C = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        prog_we = 1'b0;
  logic [2:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic        start = 1'b0;
  logic [15:0] instruction;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  pc;

  tpu_sequencer #(
    .IMEM_DEPTH(D),
    .COMPUTE_CYCLES(C)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .start(start),
    .instruction(instruction),
    .busy(busy),
    .done(done),
    .error(error),
    .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  pc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mmem [D];
  logic [2:0]  m_pc = '0;
  logic        m_err = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  int          busy_seen = 0;
  int          done_seen = 0;
  int          comp_seen = 0;
  int          model_busy = 0;

  // compare the DUT against the expected trace each cycle
  always @(negedge clk) begin
    if (busy) busy_seen++;
    if (done) done_seen++;
    if (instruction[15:13] == 3'd4) comp_seen++;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (instruction !== e.ins || busy !== e.busy ||
          done !== e.done || error !== e.err || pc !== e.pc) begin
        miscompares++;
        $display("FAIL trace t=%0t got ins=%h busy=%b done=%b err=%b pc=%0d want ins=%h busy=%b done=%b err=%b pc=%0d",
                 $time, instruction, busy, done, error, pc,
                 e.ins, e.busy, e.done, e.err, e.pc);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input logic [15:0] i, input logic b,
                                   input logic d, input logic e, input int p);
    q.push_back('{i, b, d, e, 3'(p)});
  endfunction

  // expected cycle trace of one run, from the idle cycle where start is seen
  task automatic build(input bit wr0, input logic [15:0] w0);
    int         p;
    int         n;
    logic       err;
    logic [2:0] op;
    push_exp(16'h0, 1'b0, 1'b0, m_err, int'(m_pc));
    if (wr0) mmem[0] = w0;
    p = 0;
    err = 1'b0;
    model_busy = 0;
    while (1) begin
      push_exp(16'h0, 1'b1, 1'b0, 1'b0, p);
      model_busy++;
      op = mmem[3'(p)][15:13];
      if (op == 3'd0) begin
        push_exp(16'h0, 1'b1, 1'b0, 1'b0, p);
        push_exp(16'h0, 1'b1, 1'b1, 1'b0, p);
        model_busy += 2;
        break;
      end
      if (op >= 3'd6) begin
        push_exp(16'h0, 1'b1, 1'b0, 1'b0, p);
        push_exp(16'h0, 1'b1, 1'b0, 1'b1, p);
        err = 1'b1;
        model_busy += 2;
        break;
      end
      n = (op == 3'd4) ? C : 1;
      repeat (n) push_exp(mmem[3'(p)], 1'b1, 1'b0, 1'b0, p);
      model_busy += n;
      if (p == D - 1) begin
        push_exp(16'h0, 1'b1, 1'b1, 1'b0, p);
        model_busy++;
        break;
      end
      p++;
    end
    push_exp(16'h0, 1'b0, 1'b0, err, p);
    m_pc = 3'(p);
    m_err = err;
  endtask

  task automatic prog_write(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    mmem[a] = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic launch(input bit inject, input bit wr0, input logic [15:0] w0);
    int n;
    @(posedge clk); #1;
    build(wr0, w0);
    start = 1'b1;
    if (wr0) begin
      prog_we = 1'b1;
      prog_addr = 3'd0;
      prog_data = w0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    prog_we = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 400) begin
      if (inject && n == 3) begin
        prog_we = 1'b1;
        prog_addr = 3'd0;
        prog_data = 16'hE000;
        start = 1'b1;
      end else if (inject && n == 4) begin
        prog_we = 1'b0;
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    prog_we = 1'b0;
    start = 1'b0;
    if (q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL run_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] prog [D];
    logic [2:0]  op;
    int          b0, d0, c0, cnt, k;
    bit          hit;

    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_instruction", int'(instruction), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_pc", int'(pc), 0);

    prog = '{16'h200F, 16'h4000, 16'h201E, 16'h6000,
             16'h8000, 16'h2007, 16'hA000, 16'h0000};
    for (int i = 0; i < D; i++) prog_write(3'(i), prog[i]);

    b0 = busy_seen; d0 = done_seen; c0 = comp_seen;
    launch(1'b0, 1'b0, 16'h0);
    check("default_busy_cycles", busy_seen - b0, 22);
    check("default_done_pulses", done_seen - d0, 1);
    check("default_compute_cycles", comp_seen - c0, 6);
    check("model_busy_len", model_busy, 22);

    prog_write(3'd2, 16'hC000);
    b0 = busy_seen; d0 = done_seen;
    launch(1'b0, 1'b0, 16'h0);
    check("illegal_error_sticky", int'(error), 1);
    check("illegal_done_pulses", done_seen - d0, 0);
    check("illegal_busy_cycles", busy_seen - b0, 7);
    check("model_err", int'(m_err), 1);
    prog_write(3'd2, 16'h201E);

    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (instruction[15:13] == 3'd4) cnt++;
      if (cnt == 3) hit = 1'b1;
    end
    check("third_compute_reached", int'(hit), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_instruction", int'(instruction), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_error", int'(error), 0);
    check("async_rst_pc", int'(pc), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_pc = '0;
    m_err = 1'b0;
    b0 = busy_seen; d0 = done_seen;
    launch(1'b0, 1'b0, 16'h0);
    check("restart_busy_cycles", busy_seen - b0, 22);
    check("restart_done_pulses", done_seen - d0, 1);

    b0 = busy_seen; d0 = done_seen;
    launch(1'b1, 1'b0, 16'h0);
    check("busy_start_ignored", busy_seen - b0, 22);
    check("busy_write_done", done_seen - d0, 1);
    launch(1'b0, 1'b0, 16'h0);

    for (int i = 0; i < D; i++) prog_write(3'(i), {3'b001, 13'($urandom)});
    b0 = busy_seen; d0 = done_seen;
    launch(1'b0, 1'b0, 16'h0);
    check("implicit_end_pc", int'(pc), 7);
    check("implicit_done_pulses", done_seen - d0, 1);
    check("implicit_busy_cycles", busy_seen - b0, 17);
    check("model_implicit_pc", int'(m_pc), 7);

    for (int r = 0; r < 10; r++) begin
      for (int a = 0; a < D; a++) begin
        k = $urandom_range(0, 15);
        op = 3'(k == 0 ? 0 : (k == 14 ? 6 : (k == 15 ? 7 : 1 + (k - 1) % 5)));
        prog_write(3'(a), {op, 13'($urandom)});
      end
      if (r % 2 == 1) begin
        op = 3'($urandom_range(1, 5));
        launch(1'b0, 1'b1, {op, 13'($urandom)});
      end else begin
        launch(1'b0, 1'b0, 16'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
